// File: rtl/t0_tpdu_initiator.sv
// Terminal-side ISO7816-3 T=0 TPDU engine: sends the 5-byte header, follows procedure bytes and moves data.
// Optional wait-time supervision is built only when T0_TIMEOUT_EN is defined.
module t0_tpdu_initiator #(
    parameter int TIMEOUT_W   = 22,
    parameter int WAIT_CYCLES = 3571200
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [39:0] header,
    input  logic        isWrite,
    output logic        busy,
    output logic        done,
    output logic [15:0] sw,
    output logic [1:0]  error,
    output logic [7:0]  txData,
    output logic        txValid,
    input  logic        txReady,
    input  logic [7:0]  rxData,
    input  logic        rxValid,
    output logic [7:0]  bufAddr,
    output logic [7:0]  bufWdata,
    output logic        bufWe,
    input  logic [7:0]  bufRdata
);

    typedef enum logic [2:0] {
        S_IDLE, S_HDR, S_PROC, S_TX_DATA, S_RX_DATA, S_SW2, S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic [39:0] hdr_sh_q, hdr_sh_d;
    logic [7:0]  ins_q, ins_d;
    logic        is_write_q, is_write_d;
    logic [2:0]  hdr_idx_q, hdr_idx_d;
    logic [7:0]  idx_q, idx_d;
    logic [8:0]  rem_q, rem_d;
    logic        xfer_all_q, xfer_all_d;
    logic [15:0] sw_q, sw_d;
    logic [1:0]  error_q, error_d;
    logic        waiting;
    logic        timeout;

    assign waiting = (state_q == S_PROC) || (state_q == S_RX_DATA) || (state_q == S_SW2);

`ifdef T0_TIMEOUT_EN
    logic [TIMEOUT_W-1:0] wait_cnt_q, wait_cnt_d;

    always_comb begin
        wait_cnt_d = '0;
        if (waiting && !rxValid)
            wait_cnt_d = wait_cnt_q + 1'b1;
    end

    assign timeout = waiting && !rxValid && (wait_cnt_q == TIMEOUT_W'(WAIT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (reset) wait_cnt_q <= '0;
        else       wait_cnt_q <= wait_cnt_d;
    end
`else
    // Keeps the timing parameters referenced when no counter is built.
    logic [31:0] unused_cfg;
    assign unused_cfg = 32'(WAIT_CYCLES) ^ 32'(TIMEOUT_W);
    assign timeout    = 1'b0;
`endif

    // NOTE: every combinational output and next-state gets a default first, so no latch is inferred.
    always_comb begin
        state_d    = state_q;
        hdr_sh_d   = hdr_sh_q;
        ins_d      = ins_q;
        is_write_d = is_write_q;
        hdr_idx_d  = hdr_idx_q;
        idx_d      = idx_q;
        rem_d      = rem_q;
        xfer_all_d = xfer_all_q;
        sw_d       = sw_q;
        error_d    = error_q;
        txValid    = 1'b0;
        txData     = 8'h00;
        bufWe      = 1'b0;
        bufWdata   = 8'h00;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    hdr_sh_d   = header;
                    ins_d      = header[31:24];
                    is_write_d = isWrite;
                    hdr_idx_d  = 3'd0;
                    idx_d      = 8'd0;
                    rem_d      = (!isWrite && header[7:0] == 8'h00) ? 9'd256 : {1'b0, header[7:0]};
                    sw_d       = 16'h0000;
                    error_d    = 2'd0;
                    state_d    = S_HDR;
                end
            end
            S_HDR: begin
                txValid = 1'b1;
                txData  = hdr_sh_q[39:32];
                if (txReady) begin
                    hdr_sh_d  = {hdr_sh_q[31:0], 8'h00};
                    hdr_idx_d = hdr_idx_q + 3'd1;
                    if (hdr_idx_q == 3'd4)
                        state_d = S_PROC;
                end
            end
            S_PROC: begin
                if (rxValid) begin
                    if (rxData == 8'h60) begin
                        state_d = S_PROC;
                    end else if (rxData == ins_q || rxData == ~ins_q) begin
                        if (rem_q == 9'd0) begin
                            error_d = 2'd1;
                            sw_d    = {rxData, 8'h00};
                            state_d = S_DONE;
                        end else begin
                            xfer_all_d = (rxData == ins_q);
                            state_d    = is_write_q ? S_TX_DATA : S_RX_DATA;
                        end
                    end else if (rxData[7:4] == 4'h6 || rxData[7:4] == 4'h9) begin
                        sw_d[15:8] = rxData;
                        state_d    = S_SW2;
                    end else begin
                        error_d = 2'd1;
                        sw_d    = {rxData, 8'h00};
                        state_d = S_DONE;
                    end
                end
            end
            S_TX_DATA: begin
                txValid = 1'b1;
                txData  = bufRdata;
                if (txReady) begin
                    idx_d = idx_q + 8'd1;
                    rem_d = rem_q - 9'd1;
                    if (!xfer_all_q || rem_q == 9'd1)
                        state_d = S_PROC;
                end
            end
            S_RX_DATA: begin
                if (rxValid) begin
                    bufWe    = 1'b1;
                    bufWdata = rxData;
                    idx_d    = idx_q + 8'd1;
                    rem_d    = rem_q - 9'd1;
                    if (!xfer_all_q || rem_q == 9'd1)
                        state_d = S_PROC;
                end
            end
            S_SW2: begin
                if (rxValid) begin
                    sw_d[7:0] = rxData;
                    error_d   = 2'd0;
                    state_d   = S_DONE;
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // A silent card overrides whatever the waiting state would have done.
        if (timeout) begin
            error_d = 2'd2;
            sw_d    = 16'h0000;
            state_d = S_DONE;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only; reset is synchronous and wins over all inputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            hdr_sh_q   <= '0;
            ins_q      <= '0;
            is_write_q <= 1'b0;
            hdr_idx_q  <= '0;
            idx_q      <= '0;
            rem_q      <= '0;
            xfer_all_q <= 1'b0;
            sw_q       <= '0;
            error_q    <= '0;
        end else begin
            state_q    <= state_d;
            hdr_sh_q   <= hdr_sh_d;
            ins_q      <= ins_d;
            is_write_q <= is_write_d;
            hdr_idx_q  <= hdr_idx_d;
            idx_q      <= idx_d;
            rem_q      <= rem_d;
            xfer_all_q <= xfer_all_d;
            sw_q       <= sw_d;
            error_q    <= error_d;
        end
    end

    assign busy    = (state_q != S_IDLE) && (state_q != S_DONE);
    assign done    = (state_q == S_DONE);
    assign sw      = sw_q;
    assign error   = error_q;
    assign bufAddr = idx_q;

endmodule

// File: tb/tb_t0_tpdu_initiator.sv
// Directed bench for t0_tpdu_initiator: plays the card, the UART and the data buffer.
// Build with T0_TIMEOUT_EN to exercise the wait-time abort instead of the indefinite wait.
module tb_t0_tpdu_initiator;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [39:0] header = '0;
    logic        isWrite = 1'b0;
    logic        busy, done, txValid, bufWe;
    logic [15:0] sw;
    logic [1:0]  error;
    logic [7:0]  txData, bufAddr, bufWdata, bufRdata;
    logic        txReady = 1'b1;
    logic [7:0]  rxData = 8'h00;
    logic        rxValid = 1'b0;

    logic [7:0]  mem [256];
    logic [7:0]  tx_q [$];
    int          wr_cnt = 0;
    int          done_cnt = 0;
    int          done_base = 0;
    logic [15:0] done_sw;
    logic [1:0]  done_err;
    logic        done_busy;
    bit          stall_en = 1'b0;
    int          cyc = 0;
    int          n_tests = 0;
    int          n_fail = 0;

    t0_tpdu_initiator #(.TIMEOUT_W(8), .WAIT_CYCLES(64)) dut (
        .clk(clk), .reset(reset), .start(start), .header(header), .isWrite(isWrite),
        .busy(busy), .done(done), .sw(sw), .error(error),
        .txData(txData), .txValid(txValid), .txReady(txReady),
        .rxData(rxData), .rxValid(rxValid),
        .bufAddr(bufAddr), .bufWdata(bufWdata), .bufWe(bufWe), .bufRdata(bufRdata)
    );

    always #5 clk = ~clk;

    assign bufRdata = mem[bufAddr];

    always @(posedge clk) begin
        if (txValid && txReady) tx_q.push_back(txData);
        if (bufWe) begin
            mem[bufAddr] = bufWdata;
            wr_cnt++;
        end
        if (done) begin
            done_cnt++;
            done_sw   = sw;
            done_err  = error;
            done_busy = busy;
        end
    end

    always @(negedge clk) begin
        cyc++;
        txReady = stall_en ? (cyc % 3 != 0) : 1'b1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic begin_tpdu(input logic [39:0] hdr, input logic wr);
        tx_q.delete();
        wr_cnt    = 0;
        done_base = done_cnt;
        @(negedge clk);
        header  = hdr;
        isWrite = wr;
        start   = 1'b1;
        @(negedge clk);
        start   = 1'b0;
    endtask

    task automatic send_rx(input logic [7:0] b);
        @(negedge clk);
        rxData  = b;
        rxValid = 1'b1;
        @(negedge clk);
        rxValid = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_tx(input string tag, input int n);
        for (int i = 0; i < 2000 && tx_q.size() < n; i++) @(negedge clk);
        check(tag, tx_q.size(), n);
    endtask

    task automatic wait_done(input string tag);
        for (int i = 0; i < 2000 && done_cnt == done_base; i++) @(negedge clk);
        check(tag, done_cnt - done_base, 1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        logic [7:0] exp_tx [7];
        int bad;

        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_sw", sw, 0);
        check("rst_err", error, 0);
        check("rst_txv", txValid, 0);
        check("rst_txd", txData, 0);
        check("rst_addr", bufAddr, 0);
        check("rst_we", bufWe, 0);

        // Case 3 write with ACK
        mem[0] = 8'hAA; mem[1] = 8'hBB;
        begin_tpdu(40'h00_0C_00_00_02, 1'b1);
        check("t1_busy", busy, 1);
        wait_tx("t1_hdr", 5);
        send_rx(8'h0C);
        wait_tx("t1_data", 7);
        exp_tx = '{8'h00, 8'h0C, 8'h00, 8'h00, 8'h02, 8'hAA, 8'hBB};
        bad = 0;
        for (int i = 0; i < 7; i++) if (tx_q[i] !== exp_tx[i]) bad++;
        check("t1_bytes", bad, 0);
        send_rx(8'h90);
        send_rx(8'h00);
        wait_done("t1_done");
        check("t1_sw", done_sw, 16'h9000);
        check("t1_err", done_err, 0);
        check("t1_busy_at_done", done_busy, 0);

        // Case 2 read, P3=0 means 256
        begin_tpdu(40'h00_0A_00_00_00, 1'b0);
        wait_tx("t2_hdr", 5);
        send_rx(8'h0A);
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            rxData  = 8'(i);
            rxValid = 1'b1;
            @(negedge clk);
            rxValid = 1'b0;
        end
        send_rx(8'h90);
        send_rx(8'h00);
        wait_done("t2_done");
        check("t2_wr_cnt", wr_cnt, 256);
        bad = 0;
        for (int i = 0; i < 256; i++) if (mem[i] !== 8'(i)) bad++;
        check("t2_data", bad, 0);
        check("t2_sw", done_sw, 16'h9000);

        // NULLs and single-byte procedures
        mem[0] = 8'h11; mem[1] = 8'h22;
        begin_tpdu(40'h80_0C_00_00_02, 1'b1);
        wait_tx("t3_hdr", 5);
        send_rx(8'h60);
        send_rx(8'h60);
        send_rx(8'hF3);
        wait_tx("t3_one", 6);
        check("t3_b0", tx_q[5], 8'h11);
        send_rx(8'h60);
        send_rx(8'h0C);
        wait_tx("t3_two", 7);
        check("t3_b1", tx_q[6], 8'h22);
        repeat (5) @(negedge clk);
        check("t3_no_extra", tx_q.size(), 7);
        send_rx(8'h90);
        send_rx(8'h00);
        wait_done("t3_done");
        check("t3_sw", done_sw, 16'h9000);

        // Immediate status, no data phase
        begin_tpdu(40'h00_B0_00_00_04, 1'b0);
        wait_tx("t4_hdr", 5);
        send_rx(8'h69);
        send_rx(8'h86);
        wait_done("t4_done");
        check("t4_sw", done_sw, 16'h6986);
        check("t4_err", done_err, 0);
        check("t4_no_wr", wr_cnt, 0);

        // Bad procedure byte
        begin_tpdu(40'h00_0C_00_00_02, 1'b1);
        wait_tx("t5_hdr", 5);
        send_rx(8'h55);
        wait_done("t5_done");
        check("t5_err", done_err, 1);
        check("t5_sw", done_sw, 16'h5500);

        // ACK with nothing left to transfer
        begin_tpdu(40'h00_0C_00_00_00, 1'b1);
        wait_tx("t5b_hdr", 5);
        send_rx(8'h0C);
        wait_done("t5b_done");
        check("t5b_err", done_err, 1);
        check("t5b_tx", tx_q.size(), 5);

        // Early abort after a single-byte transfer
        begin_tpdu(40'h00_0A_00_00_04, 1'b0);
        wait_tx("t5c_hdr", 5);
        send_rx(8'hF5);
        send_rx(8'h77);
        send_rx(8'h6C);
        send_rx(8'h04);
        wait_done("t5c_done");
        check("t5c_wr", wr_cnt, 1);
        check("t5c_mem", mem[0], 8'h77);
        check("t5c_sw", done_sw, 16'h6C04);

        // Silent card
        begin_tpdu(40'h00_0A_00_00_01, 1'b0);
        wait_tx("t5d_hdr", 5);
`ifdef T0_TIMEOUT_EN
        wait_done("t5d_done");
        check("t5d_err", done_err, 2);
        check("t5d_sw", done_sw, 0);
`else
        repeat (300) @(negedge clk);
        check("t5d_no_done", done_cnt - done_base, 0);
        check("t5d_still_busy", busy, 1);
        do_reset();
`endif

        // Reset in the middle of a read data phase
        begin_tpdu(40'h00_B2_00_00_04, 1'b0);
        wait_tx("t6_hdr", 5);
        send_rx(8'hB2);
        send_rx(8'h01);
        do_reset();
        check("t6_busy", busy, 0);
        check("t6_addr", bufAddr, 0);
        repeat (5) @(negedge clk);
        check("t6_no_done", done_cnt - done_base, 0);

        // Restart after reset, with a second start during the header ignored, under tx back-pressure
        stall_en = 1'b1;
        mem[0] = 8'h5A;
        begin_tpdu(40'hA0_D6_00_00_01, 1'b1);
        @(negedge clk);
        header  = 40'hFF_FF_FF_FF_FF;
        isWrite = 1'b0;
        start   = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        wait_tx("t7_hdr", 5);
        exp_tx[0:4] = '{8'hA0, 8'hD6, 8'h00, 8'h00, 8'h01};
        bad = 0;
        for (int i = 0; i < 5; i++) if (tx_q[i] !== exp_tx[i]) bad++;
        check("t7_hdr_bytes", bad, 0);
        send_rx(8'hD6);
        wait_tx("t7_data", 6);
        check("t7_b0", tx_q[5], 8'h5A);
        send_rx(8'h90);
        send_rx(8'h00);
        wait_done("t7_done");
        check("t7_sw", done_sw, 16'h9000);
        stall_en = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
